// File: rtl/ctr_stream_v3_pkg.sv
// Shared constants and types for the CTR-mode stream wrapper around the PRESENT-80 core.
package ctr_stream_v3_pkg;

  localparam int B   = 64;
  localparam int K   = 80;
  localparam int R   = 31;
  localparam int IVW = 32;
  localparam int CW  = B - IVW;
  localparam int D   = 32;
  localparam int NW  = 16;
  localparam int DCW = $clog2(D) + 1;
  localparam int IFW = $clog2(R + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // PRESENT-80 reference ciphertexts for plaintext 0 under key 0 and key all-ones.
  localparam logic [B-1:0] PRESENT_KAT_ZERO = 64'h5579c1387b228445;
  localparam logic [B-1:0] PRESENT_KAT_ONES = 64'he72c46c0f5945049;

endpackage

// File: rtl/ctr_stream_v3_ks_fifo.sv
// Keystream FIFO: synchronous, power-of-two depth, async-reset pointers and count.
module ks_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ctr_stream_v3.sv
// CTR-mode front/back end: issues {iv, ctr} blocks into the pipelined core and XORs
// the returning keystream with the plaintext stream. Encrypt and decrypt are identical.
module ctr_stream_v3
  import ctr_stream_v3_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [K-1:0]   key,
  input  logic [IVW-1:0] iv,
  input  logic [NW-1:0]  nblk,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [B-1:0]   in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [B-1:0]   out_data,
  output logic           busy,
  output logic           done,
  output logic [K-1:0]   enc_K,
  output logic [B-1:0]   enc_M,
  input  logic [B-1:0]   enc_C,
  output state_t         dbg_state
);

  // Handshake: a plaintext word and an output word move together in the single
  // cycle where in_valid && out_ready && keystream available (fire); in_ready and
  // out_valid are combinational views of that condition from each side.

  state_t          state;
  logic [K-1:0]    key_l;
  logic [IVW-1:0]  iv_l;
  logic [NW-1:0]   nblk_l;
  logic [NW-1:0]   issued;
  logic [NW-1:0]   consumed;
  logic [CW-1:0]   ctr;
  logic [R-1:0]    tag;
  logic [IFW-1:0]  inflight;

  logic [B-1:0]    fifo_head;
  logic [DCW-1:0]  fifo_count;
  logic            fifo_empty;
  logic            fifo_full;
  logic            fifo_push;
  logic            fire;
  logic            can_issue;
  logic [DCW:0]    occupancy;
  logic [NW-1:0]   issued_nxt;
  logic [NW-1:0]   consumed_nxt;

  // Reserving FIFO space for every in-flight tag means the core never needs back-pressure.
  assign occupancy    = (DCW+1)'(inflight) + (DCW+1)'(fifo_count);
  assign can_issue    = (state == ST_RUN) && (issued < nblk_l) && (occupancy < (DCW+1)'(D));
  assign fifo_push    = tag[R-1];
  assign fire         = in_valid && out_ready && !fifo_empty;
  assign issued_nxt   = issued + NW'(can_issue);
  assign consumed_nxt = consumed + NW'(fire);

  assign out_valid = in_valid && !fifo_empty;
  assign in_ready  = out_ready && !fifo_empty;
  assign out_data  = in_data ^ fifo_head;
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  ks_fifo #(.W(B), .DEPTH(D)) u_ks_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push && !fifo_full),
    .push_data (enc_C),
    .pop       (fire),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      key_l    <= '0;
      iv_l     <= '0;
      nblk_l   <= '0;
      issued   <= '0;
      consumed <= '0;
      ctr      <= '0;
      tag      <= '0;
      inflight <= '0;
      enc_K    <= '0;
      enc_M    <= '0;
      done     <= 1'b0;
    end else begin
      done  <= 1'b0;
      tag   <= {tag[R-2:0], can_issue};
      enc_K <= key_l;
      enc_M <= can_issue ? {iv_l, ctr} : '0;
      if (can_issue) begin
        ctr    <= ctr + CW'(1);
        issued <= issued_nxt;
      end
      if (fire) consumed <= consumed_nxt;
      case ({can_issue, tag[R-1]})
        2'b10:   inflight <= inflight + IFW'(1);
        2'b01:   inflight <= inflight - IFW'(1);
        default: inflight <= inflight;
      endcase

      case (state)
        ST_IDLE: begin
          if (start) begin
            key_l    <= key;
            iv_l     <= iv;
            nblk_l   <= nblk;
            ctr      <= '0;
            issued   <= '0;
            consumed <= '0;
            if (nblk == '0) begin
              state <= ST_FIN;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (issued_nxt == nblk_l) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (consumed_nxt == nblk_l) begin
            state <= ST_FIN;
            done  <= 1'b1;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
